// File: rtl/ecc_secded_correct.sv
// SECDED check/correct stage for the FIFO read path: two-stage pipeline that
// corrects single-bit errors, flags double-bit errors and keeps error statistics.
module ecc_secded_correct #(
   parameter int DATA_WIDTH        = 32,
   parameter int PARITY_BITS       = 6,
   parameter int MEMORY_DATA_WIDTH = 39,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [MEMORY_DATA_WIDTH-1:0] codeword_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic [DATA_WIDTH-1:0]        data_o,
   output logic                         sec_o,
   output logic                         ded_o,
   output logic [PARITY_BITS-1:0]       syndrome_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   input  logic                         cnt_clr_i,
   output logic [CNT_WIDTH-1:0]         sec_cnt_o,
   output logic [CNT_WIDTH-1:0]         ded_cnt_o,
   output logic                         first_err_vld_o,
   output logic [PARITY_BITS-1:0]       first_err_syn_o,
   output logic                         first_err_ded_o
);

   // Handshake: a word moves across an interface on a rising edge where valid
   // and ready are both high; a stage loads when empty or when its word leaves
   // in that same cycle, so ready_o depends combinationally on ready_i.
   logic                         s1_valid;
   logic [MEMORY_DATA_WIDTH-1:0] s1_cw;
   logic [PARITY_BITS-1:0]       s1_syn;
   logic                         s1_par;

   logic                         s1_load;
   logic                         s2_load;
   logic                         out_xfer;

   logic [PARITY_BITS-1:0]       syn_next;
   logic                         par_next;

   logic                         cls_sec;
   logic                         cls_ded;
   logic [MEMORY_DATA_WIDTH-1:0] fixed_cw;
   logic [DATA_WIDTH-1:0]        fixed_data;

   assign s2_load  = !valid_o || ready_i;
   assign s1_load  = !s1_valid || s2_load;
   assign ready_o  = s1_load;
   assign out_xfer = valid_o && ready_i;

   // Each set codeword bit contributes its own position to the syndrome.
   always_comb begin
      syn_next = '0;
      par_next = ^codeword_i;
      for (int k = 1; k < MEMORY_DATA_WIDTH; k++) begin
         if (codeword_i[k]) begin
            syn_next = syn_next ^ PARITY_BITS'(k);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= valid_i;
         s1_cw    <= codeword_i;
         s1_syn   <= syn_next;
         s1_par   <= par_next;
      end
   end

   // A syndrome of 0 with odd parity points at the overall bit, which is not data.
   always_comb begin
      cls_sec  = s1_par && (s1_syn <= PARITY_BITS'(MEMORY_DATA_WIDTH - 1));
      cls_ded  = (!s1_par && (s1_syn != '0)) ||
                 (s1_par && (s1_syn > PARITY_BITS'(MEMORY_DATA_WIDTH - 1)));
      fixed_cw = s1_cw;
      if (cls_sec) begin
         fixed_cw = s1_cw ^ (MEMORY_DATA_WIDTH'(1) << s1_syn);
      end
      fixed_data = {fixed_cw[38:33], fixed_cw[31:17], fixed_cw[15:9],
                    fixed_cw[7:5], fixed_cw[3]};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o    <= 1'b0;
         data_o     <= '0;
         sec_o      <= 1'b0;
         ded_o      <= 1'b0;
         syndrome_o <= '0;
      end else if (s2_load) begin
         valid_o    <= s1_valid;
         data_o     <= fixed_data;
         sec_o      <= s1_valid && cls_sec;
         ded_o      <= s1_valid && cls_ded;
         syndrome_o <= s1_syn;
      end
   end

   // Statistics follow accepted output words only; a clear beats a same-cycle event.
   always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
         sec_cnt_o       <= '0;
         ded_cnt_o       <= '0;
         first_err_vld_o <= 1'b0;
         first_err_syn_o <= '0;
         first_err_ded_o <= 1'b0;
      end else if (out_xfer) begin
         if (sec_o && (sec_cnt_o != '1)) begin
            sec_cnt_o <= sec_cnt_o + CNT_WIDTH'(1);
         end
         if (ded_o && (ded_cnt_o != '1)) begin
            ded_cnt_o <= ded_cnt_o + CNT_WIDTH'(1);
         end
         if ((sec_o || ded_o) && !first_err_vld_o) begin
            first_err_vld_o <= 1'b1;
            first_err_syn_o <= syndrome_o;
            first_err_ded_o <= ded_o;
         end
      end
   end

endmodule

// File: tb/tb_ecc_secded_correct.sv
// Directed bench for ecc_secded_correct: single words with known error patterns,
// streaming with back-pressure, counter saturation/clear and mid-stream reset.
module tb_ecc_secded_correct;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [38:0] codeword_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_o;
   logic        sec_o;
   logic        ded_o;
   logic [5:0]  syndrome_o;
   logic        valid_o;
   logic        ready_i;
   logic        cnt_clr_i;
   logic [15:0] sec_cnt_o;
   logic [15:0] ded_cnt_o;
   logic        first_err_vld_o;
   logic [5:0]  first_err_syn_o;
   logic        first_err_ded_o;

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q[$];

   logic [31:0] got_data;
   logic        got_sec;
   logic        got_ded;
   logic [5:0]  got_syn;

   logic [38:0] base_cw;
   logic [38:0] sec_cw;
   int          seen;

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   ecc_secded_correct dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .codeword_i      (codeword_i),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .data_o          (data_o),
      .sec_o           (sec_o),
      .ded_o           (ded_o),
      .syndrome_o      (syndrome_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .cnt_clr_i       (cnt_clr_i),
      .sec_cnt_o       (sec_cnt_o),
      .ded_cnt_o       (ded_cnt_o),
      .first_err_vld_o (first_err_vld_o),
      .first_err_syn_o (first_err_syn_o),
      .first_err_ded_o (first_err_ded_o)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference encoder: data into non-power-of-two positions, then parity bits.
   function automatic logic [38:0] encode(input logic [31:0] d);
      logic [38:0] cw;
      logic        p;
      int          idx;
      cw  = '0;
      idx = 0;
      for (int k = 1; k < 39; k++) begin
         if ((k & (k - 1)) != 0) begin
            cw[k] = d[idx];
            idx++;
         end
      end
      for (int j = 0; j < 6; j++) begin
         p = 1'b0;
         for (int k = 1; k < 39; k++) begin
            if (k[j]) p = p ^ cw[k];
         end
         cw[1 << j] = p;
      end
      cw[0] = ^cw[38:1];
      return cw;
   endfunction

   function automatic logic [31:0] stream_data(input int i);
      return (32'h1000_0001 * (i + 1)) ^ 32'hA5A5_5A5A;
   endfunction

   function automatic logic [38:0] stream_word(input int i);
      logic [38:0] cw;
      cw = encode(stream_data(i));
      if (i % 2 == 1) cw[(i * 5) % 39] = ~cw[(i * 5) % 39];
      return cw;
   endfunction

   // ---------------- drivers ----------------
   // Sends one word into an empty pipeline and captures the result; optionally
   // asserts cnt_clr_i in the cycle the result is taken.
   task automatic xfer_one(input logic [38:0] cw, input logic clr_on_out);
      @(negedge clk_i);
      codeword_i = cw;
      valid_i    = 1'b1;
      ready_i    = 1'b1;
      #1;
      check("ready_o_accept", ready_o, 1);
      @(negedge clk_i);
      valid_i = 1'b0;
      check("latency_1_valid_o", valid_o, 0);
      @(negedge clk_i);
      check("latency_2_valid_o", valid_o, 1);
      got_data  = data_o;
      got_sec   = sec_o;
      got_ded   = ded_o;
      got_syn   = syndrome_o;
      cnt_clr_i = clr_on_out;
      @(negedge clk_i);
      cnt_clr_i = 1'b0;
   endtask

   task automatic run_stream(input logic toggle);
      int          sent;
      int          rcv;
      int          cyc;
      logic        hold_v;
      logic [31:0] hold_d;
      logic [32:0] e;
      sent   = 0;
      rcv    = 0;
      hold_v = 1'b0;
      hold_d = '0;
      for (cyc = 0; cyc < 200 && rcv < 8; cyc++) begin
         @(negedge clk_i);
         ready_i = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (sent < 8) begin
            valid_i    = 1'b1;
            codeword_i = stream_word(sent);
         end else begin
            valid_i = 1'b0;
         end
         #1;
         if (hold_v) begin
            check("stall_valid_hold", valid_o, 1);
            check("stall_data_hold", data_o, hold_d);
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("stream_unexpected_word", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("stream_data", data_o, e[31:0]);
               check("stream_sec", sec_o, e[32]);
            end
            rcv++;
         end
         hold_v = valid_o && !ready_i;
         hold_d = data_o;
         if (valid_i && ready_o) begin
            exp_q.push_back({(sent % 2 == 1) ? 1'b1 : 1'b0, stream_data(sent)});
            sent++;
         end
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      check("stream_words_out", rcv, 8);
      check("stream_queue_empty", exp_q.size(), 0);
      if (!toggle) check("stream_full_rate_cycles", cyc, 10);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_i      = 1'b1;
      valid_i    = 1'b0;
      ready_i    = 1'b0;
      cnt_clr_i  = 1'b0;
      codeword_i = '0;
      repeat (2) @(negedge clk_i);
      check("rst_valid_o", valid_o, 0);
      check("rst_data_o", data_o, 0);
      check("rst_flags", {sec_o, ded_o, syndrome_o}, 0);
      check("rst_counters", {sec_cnt_o, ded_cnt_o}, 0);
      check("rst_capture", {first_err_vld_o, first_err_syn_o, first_err_ded_o}, 0);
      check("rst_ready_o", ready_o, 1);
      rst_i = 1'b0;

      base_cw = encode(32'hDEAD_BEEF);

      // Clean word
      xfer_one(base_cw, 1'b0);
      check("clean_data", got_data, 32'hDEAD_BEEF);
      check("clean_flags", {got_sec, got_ded, got_syn}, 0);
      check("clean_counters", {sec_cnt_o, ded_cnt_o}, 0);
      check("clean_capture_vld", first_err_vld_o, 0);

      // Single error at position 5 (data bit 1)
      xfer_one(base_cw ^ (39'd1 << 5), 1'b0);
      check("sec5_data", got_data, 32'hDEAD_BEEF);
      check("sec5_sec", got_sec, 1);
      check("sec5_ded", got_ded, 0);
      check("sec5_syn", got_syn, 5);
      check("sec5_sec_cnt", sec_cnt_o, 1);
      check("sec5_capture", {first_err_vld_o, first_err_syn_o, first_err_ded_o}, {1'b1, 6'd5, 1'b0});

      // Only the overall parity bit flipped
      xfer_one(base_cw ^ 39'd1, 1'b0);
      check("sec0_data", got_data, 32'hDEAD_BEEF);
      check("sec0_flags", {got_sec, got_ded, got_syn}, {1'b1, 1'b0, 6'd0});
      check("sec0_sec_cnt", sec_cnt_o, 2);

      // Highest position, data bit 31
      xfer_one(base_cw ^ (39'd1 << 38), 1'b0);
      check("sec38_data", got_data, 32'hDEAD_BEEF);
      check("sec38_flags", {got_sec, got_ded, got_syn}, {1'b1, 1'b0, 6'd38});

      // Double error at positions 3 and 5
      xfer_one(base_cw ^ (39'd1 << 3) ^ (39'd1 << 5), 1'b0);
      check("ded35_data", got_data, 32'hDEAD_BEEF ^ 32'h3);
      check("ded35_flags", {got_sec, got_ded, got_syn}, {1'b0, 1'b1, 6'd6});
      check("ded35_ded_cnt", ded_cnt_o, 1);
      check("ded35_capture_kept", {first_err_vld_o, first_err_syn_o, first_err_ded_o}, {1'b1, 6'd5, 1'b0});

      // Triple error giving odd parity and syndrome 47 (out of range)
      xfer_one(base_cw ^ (39'd1 << 7) ^ (39'd1 << 8) ^ (39'd1 << 32), 1'b0);
      check("ded47_data", got_data, 32'hDEAD_BEEF ^ 32'h8);
      check("ded47_flags", {got_sec, got_ded, got_syn}, {1'b0, 1'b1, 6'd47});
      check("ded47_ded_cnt", ded_cnt_o, 2);

      // Streams: back-pressure pattern, then full rate
      run_stream(1'b1);
      run_stream(1'b0);

      // Clear, then drive the SEC counter to saturation
      @(negedge clk_i);
      cnt_clr_i = 1'b1;
      @(negedge clk_i);
      cnt_clr_i = 1'b0;
      check("clr_counters", {sec_cnt_o, ded_cnt_o}, 0);
      check("clr_capture_vld", first_err_vld_o, 0);

      sec_cw = base_cw ^ (39'd1 << 5);
      codeword_i = sec_cw;
      valid_i    = 1'b1;
      ready_i    = 1'b1;
      repeat (65534) @(negedge clk_i);
      valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("sat_sec_cnt_fffe", sec_cnt_o, 16'hFFFE);
      xfer_one(sec_cw, 1'b0);
      check("sat_sec_cnt_ffff", sec_cnt_o, 16'hFFFF);
      xfer_one(sec_cw, 1'b0);
      check("sat_sec_cnt_hold", sec_cnt_o, 16'hFFFF);
      check("sat_ded_cnt", ded_cnt_o, 0);

      // Clear coinciding with an error transfer
      xfer_one(sec_cw, 1'b1);
      check("clr_race_sec_seen", got_sec, 1);
      check("clr_race_counters", {sec_cnt_o, ded_cnt_o}, 0);
      check("clr_race_capture_vld", first_err_vld_o, 0);

      // Reset with two words in flight
      xfer_one(sec_cw, 1'b0);
      check("pre_rst_sec_cnt", sec_cnt_o, 1);
      @(negedge clk_i);
      ready_i    = 1'b1;
      valid_i    = 1'b1;
      codeword_i = sec_cw;
      @(negedge clk_i);
      codeword_i = base_cw;
      @(negedge clk_i);
      valid_i = 1'b0;
      rst_i   = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("midrst_valid_o", valid_o, 0);
      check("midrst_counters", {sec_cnt_o, ded_cnt_o}, 0);
      check("midrst_capture_vld", first_err_vld_o, 0);
      check("midrst_ready_o", ready_o, 1);
      seen = 0;
      repeat (5) begin
         @(negedge clk_i);
         if (valid_o) seen++;
      end
      check("midrst_no_stale_word", seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ecc_secded_correct.md
Name: ecc_secded_correct

Overview:
- Pipelined SECDED check/correct stage on the FIFO read path.
- Consumes the 39-bit Hamming-ordered codeword produced by the read-side decoding stage and checks it against the parity bits.
- Returns corrected 32-bit data with per-word error flags, and keeps saturating SEC/DED event counters plus a first-error syndrome capture for status readout.
- Valid/ready handshake on both sides, 2-cycle latency.

Parameters:
- DATA_WIDTH, 32, payload width.
- PARITY_BITS, 6, Hamming parity bits; the overall parity bit is extra.
- MEMORY_DATA_WIDTH, 39, codeword width = DATA_WIDTH+PARITY_BITS+1.
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- codeword_i  in  MEMORY_DATA_WIDTH  Hamming-ordered codeword (bit k = position k)
- valid_i  in  1  codeword_i valid
- ready_o  out  1  stage can accept
- data_o  out  DATA_WIDTH  corrected data
- sec_o  out  1  single error corrected in this word
- ded_o  out  1  uncorrectable error in this word
- syndrome_o  out  PARITY_BITS  syndrome of this word
- valid_o  out  1  data_o/flags valid
- ready_i  in  1  downstream accepts
- cnt_clr_i  in  1  clear counters and capture
- sec_cnt_o  out  CNT_WIDTH  saturating count of SEC words
- ded_cnt_o  out  CNT_WIDTH  saturating count of DED words
- first_err_vld_o  out  1  first-error capture valid
- first_err_syn_o  out  PARITY_BITS  syndrome of first error since clear
- first_err_ded_o  out  1  first captured error was DED

Behaviour:
- Codeword layout:
  - Bit 0 is overall parity.
  - Bits 1,2,4,8,16,32 are Hamming parity.
  - Data bits fill the remaining indices ascending: data[0]=bit3, data[3:1]=bits7:5, data[10:4]=bits15:9, data[25:11]=bits31:17, data[31:26]=bits38:33.
- Syndrome: s[j] = XOR of codeword bits k in 1..38 with bit j of k set. Overall parity P = XOR of all 39 bits. A valid codeword has s=0 and P=0.
- Classification:
  - s=0, P=0: clean.
  - P=1, s<=38: SEC; invert bit s (s=0 means only the overall bit flipped, so data is unchanged).
  - s!=0, P=0: DED.
  - P=1, s>38: DED.
  - On DED, data_o carries the uncorrected extracted data.
- Pipeline:
  - Stage 1 registers the codeword plus s and P.
  - Stage 2 registers data_o, sec_o, ded_o, syndrome_o and valid_o.
  - Latency: valid_i&ready_o at cycle N gives valid_o at N+2 when ready_i is held high.
- Handshake:
  - A stage loads when it is empty or its content is taken in the same cycle.
  - ready_o = !s1_valid | s2_load; this is combinational from ready_i.
  - Full throughput of 1 word/clk.
  - While valid_o=1 and ready_i=0, all outputs hold stable; no word is dropped or duplicated.
- Counters:
  - sec_cnt_o increments by 1 and ded_cnt_o increments by 1 on the output transfer (valid_o&ready_i) of a SEC or DED word, respectively.
  - Both saturate at 2^CNT_WIDTH-1.
- First-error capture:
  - On the first SEC/DED output transfer while first_err_vld_o=0, latch syndrome and DED flag and set first_err_vld_o.
  - Later errors do not overwrite the capture.
- cnt_clr_i:
  - Clears both counters and the capture next cycle.
  - If an error transfer occurs in the same cycle, the clear wins: counters read 0 and the capture stays empty.
  - Does not affect pipeline data.
- Reset: all outputs are 0 one cycle after rst_i is sampled high, including valid_o, flags, data_o, syndrome_o, counters and capture. ready_o is 1 after reset. Reset mid-stream discards in-flight words.

Test Plan:
- Clean word, data 0xDEADBEEF correctly encoded, ready_i=1 -> data_o=0xDEADBEEF two cycles later; sec_o=0, ded_o=0, syndrome_o=0; counters unchanged.
- Same word with bit 5 flipped -> data_o=0xDEADBEEF, sec_o=1, syndrome_o=5, sec_cnt_o=1, first_err_vld_o=1, first_err_syn_o=5, first_err_ded_o=0.
- Bit 0 flipped -> sec_o=1, syndrome_o=0, data_o unchanged. Bits 3 and 5 flipped -> ded_o=1, syndrome_o=6, data_o=0xDEADBEEF^0x3, ded_cnt_o increments, first-error capture unchanged.
- 8 back-to-back words with ready_i toggling 1,0,0,1 -> outputs in order, no loss or duplication; outputs stable while stalled; throughput 1/clk when ready_i=1.
- Preload sec_cnt_o to 0xFFFE via 3 SEC words after forcing -> saturates at 0xFFFF. Assert cnt_clr_i with a simultaneous error transfer -> counters read 0 and first_err_vld_o=0.
- Assert rst_i for 1 cycle with 2 words in flight -> valid_o=0 and counters 0 next cycle; no stale word emerges afterwards.
